fpu_issue_arbiter: RTL and testbench

Shares one pipelined FPU among NUM_REQ requesters.
- Each cycle, round-robin selects at most one valid requester.
- The selected requester's Operand1/Operand2/Operation go to the FPU.
- A tag travels alongside the op through a latency-matched shift register, so each Result returns to its originator.
- Per-requester in-flight limits bound response traffic.
- Sits between the core-side requesters and the FPU instance.

---
 rtl/fpu_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/fpu_issue_arbiter.sv | 137 +++++++++++++
 tb/tb_fpu_issue_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU interface definitions: data and opcode widths, opcode values
// and the issue tag that travels alongside each operation.
package fpu_pkg;

   localparam int FPU_DATA_W      = 32;
   localparam int FPU_OP_W        = 2;
   localparam int FPU_LATENCY_DEF = 8;
   localparam int TAG_ID_W        = 3;   // wide enough for up to 8 requesters

   typedef enum logic [FPU_OP_W-1:0] {
      FPU_ADD = 2'd0,
      FPU_SUB = 2'd1,
      FPU_MUL = 2'd2,
      FPU_DIV = 2'd3
   } fpu_opc_e;

   typedef struct packed {
      logic                valid;
      logic [TAG_ID_W-1:0] id;
   } fpu_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first eligible requester at or after
// rr_ptr (wrapping), as a one-hot vector plus its encoded index.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] eligible,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx
);

   logic [NUM_REQ-1:0] rotated;
   logic [IDX_W:0]     offset_sum;
   logic               found;

   // NOTE: every variable gets a default at the top of the block so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      grant      = '0;
      grant_idx  = '0;
      offset_sum = '0;
      found      = 1'b0;
      rotated    = NUM_REQ'({eligible, eligible} >> rr_ptr);
      // Descending scan: the smallest offset from rr_ptr is written last and wins.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (rotated[k]) begin
            found      = 1'b1;
            offset_sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
         end
      end
      if (offset_sum >= (IDX_W+1)'(NUM_REQ)) begin
         offset_sum = offset_sum - (IDX_W+1)'(NUM_REQ);
      end
      if (found) begin
         grant_idx        = offset_sum[IDX_W-1:0];
         grant[grant_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/fpu_issue_arbiter.sv
// Shares one pipelined FPU among NUM_REQ requesters: round-robin issue,
// latency-matched tag pipe to route results back, per-requester credit limits.
module fpu_issue_arbiter
   import fpu_pkg::*;
#(
   parameter int NUM_REQ         = 4,
   parameter int FPU_LATENCY     = FPU_LATENCY_DEF,
   parameter int MAX_OUTSTANDING = 4,
   parameter int ID_W            = $clog2(NUM_REQ)
) (
   input  logic                           CLK,
   input  logic                           RST_N,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic [NUM_REQ*FPU_DATA_W-1:0]  req_op1,
   input  logic [NUM_REQ*FPU_DATA_W-1:0]  req_op2,
   input  logic [NUM_REQ*FPU_OP_W-1:0]    req_opc,
   output logic [FPU_DATA_W-1:0]          fpu_op1,
   output logic [FPU_DATA_W-1:0]          fpu_op2,
   output logic [FPU_OP_W-1:0]            fpu_opc,
   input  logic [FPU_DATA_W-1:0]          fpu_result,
   output logic                           rsp_valid,
   output logic [ID_W-1:0]                rsp_id,
   output logic [FPU_DATA_W-1:0]          rsp_result,
   output logic                           busy
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

   logic [ID_W-1:0]       rr_ptr;
   logic [NUM_REQ-1:0]    eligible;
   logic [NUM_REQ-1:0]    grant;
   logic [NUM_REQ-1:0]    retire;
   logic [ID_W-1:0]       grant_idx;
   logic                  handshake;
   logic [CNT_W-1:0]      cnt [NUM_REQ];
   fpu_tag_t              tag_pipe [FPU_LATENCY+1];
   logic [FPU_DATA_W-1:0] sel_op1;
   logic [FPU_DATA_W-1:0] sel_op2;
   logic [FPU_OP_W-1:0]   sel_opc;

   // A response retiring this cycle frees its slot for an issue in the same cycle.
   always_comb begin
      retire = '0;
      if (rsp_valid) retire[rsp_id] = 1'b1;
      eligible = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         eligible[i] = req_valid[i] &&
                       ((cnt[i] < CNT_W'(MAX_OUTSTANDING)) || retire[i]);
      end
   end

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (ID_W)
   ) u_rr_arbiter (
      .eligible  (eligible),
      .rr_ptr    (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign req_ready = grant;
   assign handshake = |grant;

   always_comb begin
      sel_op1 = '0;
      sel_op2 = '0;
      sel_opc = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_op1 = req_op1[i*FPU_DATA_W +: FPU_DATA_W];
            sel_op2 = req_op2[i*FPU_DATA_W +: FPU_DATA_W];
            sel_opc = req_opc[i*FPU_OP_W +: FPU_OP_W];
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rr_ptr  <= '0;
         fpu_op1 <= '0;
         fpu_op2 <= '0;
         fpu_opc <= '0;
         for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
      end else begin
         if (handshake) begin
            fpu_op1 <= sel_op1;
            fpu_op2 <= sel_op2;
            fpu_opc <= sel_opc;
            rr_ptr  <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            case ({grant[i], retire[i]})
               2'b10:   cnt[i] <= cnt[i] + 1'b1;
               2'b01:   cnt[i] <= cnt[i] - 1'b1;
               default: cnt[i] <= cnt[i];
            endcase
         end
      end
   end

   // NOTE: the tag pipe is a register array, not RAM; every stage is reset so
   // tags in flight at reset can never produce a response.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int k = 0; k <= FPU_LATENCY; k++) tag_pipe[k] <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= '0;
         rsp_result <= '0;
      end else begin
         tag_pipe[0].valid <= handshake;
         tag_pipe[0].id    <= TAG_ID_W'(grant_idx);
         for (int k = 1; k <= FPU_LATENCY; k++) tag_pipe[k] <= tag_pipe[k-1];
         rsp_valid <= tag_pipe[FPU_LATENCY].valid;
         if (tag_pipe[FPU_LATENCY].valid) begin
            rsp_id     <= tag_pipe[FPU_LATENCY].id[ID_W-1:0];
            rsp_result <= fpu_result;
         end
      end
   end

   always_comb begin
      busy = 1'b0;
      for (int k = 0; k <= FPU_LATENCY; k++) busy = busy | tag_pipe[k].valid;
   end

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_check
      a_no_underflow: assert property (@(posedge CLK) disable iff (!RST_N)
         retire[g] |-> (cnt[g] != '0));
      a_no_overflow: assert property (@(posedge CLK) disable iff (!RST_N)
         cnt[g] <= CNT_W'(MAX_OUTSTANDING));
   end

endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// Self-checking bench for fpu_issue_arbiter: arbitration vector table, an
// in-order response scoreboard fed by a latency-accurate FPU model, and corner sequences.
module tb_fpu_issue_arbiter;
   import fpu_pkg::*;

   localparam int N    = 4;
   localparam int L    = 8;
   localparam int MAXO = 4;
   localparam int IDW  = $clog2(N);

   logic            CLK = 1'b0;
   logic            RST_N;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*32-1:0] req_op1;
   logic [N*32-1:0] req_op2;
   logic [N*2-1:0]  req_opc;
   logic [31:0]     fpu_op1;
   logic [31:0]     fpu_op2;
   logic [1:0]      fpu_opc;
   logic [31:0]     fpu_result;
   logic            rsp_valid;
   logic [IDW-1:0]  rsp_id;
   logic [31:0]     rsp_result;
   logic            busy;

   fpu_issue_arbiter #(
      .NUM_REQ         (N),
      .FPU_LATENCY     (L),
      .MAX_OUTSTANDING (MAXO)
   ) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op1    (req_op1),
      .req_op2    (req_op2),
      .req_opc    (req_opc),
      .fpu_op1    (fpu_op1),
      .fpu_op2    (fpu_op2),
      .fpu_opc    (fpu_opc),
      .fpu_result (fpu_result),
      .rsp_valid  (rsp_valid),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .busy       (busy)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Integer stand-in for the FPU datapath; only routing and timing are under test.
   function automatic logic [31:0] fpu_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [1:0] opc);
      case (fpu_opc_e'(opc))
         FPU_ADD: return a + b;
         FPU_SUB: return a - b;
         FPU_MUL: return a * b;
         default: return a ^ b;
      endcase
   endfunction

   // FPU samples its inputs each edge and presents the result L cycles later.
   logic [31:0] fpu_pipe [L];
   always @(posedge CLK) begin
      fpu_pipe[0] <= fpu_model(fpu_op1, fpu_op2, fpu_opc);
      for (int k = 1; k < L; k++) fpu_pipe[k] <= fpu_pipe[k-1];
   end
   assign fpu_result = fpu_pipe[L-1];

   typedef struct {
      logic [IDW-1:0] id;
      logic [31:0]    res;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        sb_head;
   int          hs_count   = 0;
   int          onehot_err = 0;
   logic [31:0] last_op1 = '0;
   logic [31:0] last_op2 = '0;
   logic [1:0]  last_opc = '0;

   always @(negedge CLK) begin
      if (RST_N) begin
         if ($countones(req_ready) > 1) onehot_err++;
         for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               last_op1 = req_op1[i*32 +: 32];
               last_op2 = req_op2[i*32 +: 32];
               last_opc = req_opc[i*2 +: 2];
               sb_q.push_back('{id: IDW'(i), res: fpu_model(last_op1, last_op2, last_opc)});
               hs_count++;
            end
         end
         if (rsp_valid) begin
            check("rsp_expected", sb_q.size() != 0, 1'b1);
            if (sb_q.size() != 0) begin
               sb_head = sb_q.pop_front();
               check("rsp_id", rsp_id, sb_head.id);
               check("rsp_result", rsp_result, sb_head.res);
            end
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic rand_ops();
      for (int i = 0; i < N; i++) begin
         req_op1[i*32 +: 32] = $urandom();
         req_op2[i*32 +: 32] = $urandom();
         req_opc[i*2 +: 2]   = 2'($urandom_range(0, 3));
      end
   endtask

   task automatic idle_wait();
      int n;
      n = 0;
      tick();
      req_valid = '0;
      @(negedge CLK);
      while ((busy || rsp_valid) && n < 100) begin
         @(negedge CLK);
         n++;
      end
      check("drain_busy", busy, 1'b0);
   endtask

   typedef struct packed {
      logic [N-1:0] valid;
      logic [N-1:0] ready;
   } arb_vec_t;

   arb_vec_t    arb_tab [11];
   logic [N-1:0] exp_rdy;
   int          lat, prev, cur, rot_err, start, quiet;
   int          grant_cnt [N];

   initial begin
      // Consecutive arbitration steps from reset (rr_ptr=0, no credits used).
      arb_tab[0]  = '{valid: 4'b0000, ready: 4'b0000};
      arb_tab[1]  = '{valid: 4'b1010, ready: 4'b0010};
      arb_tab[2]  = '{valid: 4'b1010, ready: 4'b1000};
      arb_tab[3]  = '{valid: 4'b0101, ready: 4'b0001};
      arb_tab[4]  = '{valid: 4'b0101, ready: 4'b0100};
      arb_tab[5]  = '{valid: 4'b0001, ready: 4'b0001};
      arb_tab[6]  = '{valid: 4'b1111, ready: 4'b0010};
      arb_tab[7]  = '{valid: 4'b1001, ready: 4'b1000};
      arb_tab[8]  = '{valid: 4'b0110, ready: 4'b0010};
      arb_tab[9]  = '{valid: 4'b0000, ready: 4'b0000};
      arb_tab[10] = '{valid: 4'b1000, ready: 4'b1000};

      RST_N = 1'b0;
      req_valid = '0;
      req_op1 = '0;
      req_op2 = '0;
      req_opc = '0;
      #12;
      check("reset_rsp_valid", rsp_valid, 1'b0);
      check("reset_rsp_id", rsp_id, '0);
      check("reset_rsp_result", rsp_result, '0);
      check("reset_fpu_op1", fpu_op1, '0);
      check("reset_fpu_op2", fpu_op2, '0);
      check("reset_fpu_opc", fpu_opc, '0);
      check("reset_busy", busy, 1'b0);
      req_valid = '1;
      #1;
      check("reset_rr_ptr_grant", req_ready, 4'b0001);
      req_valid = '0;
      @(negedge CLK);
      RST_N = 1'b1;

      for (int k = 0; k < 11; k++) begin
         tick();
         req_valid = arb_tab[k].valid;
         rand_ops();
         @(negedge CLK);
         check($sformatf("arb_ready_%0d", k), req_ready, arb_tab[k].ready);
      end

      // Single op from requester 2: latency, routing and busy.
      idle_wait();
      tick();
      req_valid = 4'b0100;
      req_op1[2*32 +: 32] = 32'h3F80_0000;
      req_op2[2*32 +: 32] = 32'h4000_0000;
      req_opc[2*2 +: 2]   = 2'd2;
      @(negedge CLK);
      check("single_ready", req_ready, 4'b0100);
      tick();
      req_valid = '0;
      @(negedge CLK);
      check("single_fpu_op1", fpu_op1, 32'h3F80_0000);
      check("single_fpu_op2", fpu_op2, 32'h4000_0000);
      check("single_fpu_opc", fpu_opc, 2'd2);
      check("single_busy", busy, 1'b1);
      lat = 1;
      while (!rsp_valid && lat < 40) begin
         @(negedge CLK);
         lat++;
      end
      check("single_latency", lat, L + 2);
      check("single_rsp_id", rsp_id, 2'd2);
      check("single_rsp_result", rsp_result, fpu_model(32'h3F80_0000, 32'h4000_0000, 2'd2));
      @(negedge CLK);
      check("single_busy_after", busy, 1'b0);
      check("single_rsp_pulse", rsp_valid, 1'b0);

      // Credit limit on requester 1, with same-cycle resume on retire.
      idle_wait();
      for (int k = 0; k < 15; k++) begin
         tick();
         req_valid = 4'b0010;
         rand_ops();
         @(negedge CLK);
         exp_rdy = ((k < MAXO) || (k >= L + 2 && k < L + 2 + MAXO)) ? 4'b0010 : 4'b0000;
         check($sformatf("credit_ready_%0d", k), req_ready, exp_rdy);
      end

      // Fairness: all requesters valid for 400 cycles.
      idle_wait();
      for (int i = 0; i < N; i++) grant_cnt[i] = 0;
      prev = -1;
      rot_err = 0;
      for (int c = 0; c < 400; c++) begin
         tick();
         req_valid = '1;
         rand_ops();
         @(negedge CLK);
         cur = -1;
         for (int i = 0; i < N; i++) if (req_ready[i]) cur = i;
         if (cur >= 0) grant_cnt[cur]++;
         if (cur < 0 || (prev >= 0 && cur != (prev + 1) % N)) rot_err++;
         prev = cur;
      end
      check("fair_rotation_errors", rot_err, 0);
      for (int i = 0; i < N; i++) check($sformatf("fair_share_%0d", i), grant_cnt[i], 100);

      // Random interleaved traffic from requesters 0..2.
      idle_wait();
      start = hs_count;
      for (int c = 0; c < 30000 && (hs_count - start) < 10000; c++) begin
         tick();
         for (int i = 0; i < 3; i++) req_valid[i] = ($urandom_range(0, 3) != 0);
         req_valid[3] = 1'b0;
         rand_ops();
      end
      check("random_ops_issued", (hs_count - start) >= 10000, 1'b1);

      // Asynchronous reset with ops in flight.
      idle_wait();
      for (int c = 0; c < 5; c++) begin
         tick();
         req_valid = '1;
         rand_ops();
      end
      tick();
      req_valid = '0;
      #2;
      RST_N = 1'b0;
      sb_q.delete();
      #1;
      check("midrst_rsp_valid", rsp_valid, 1'b0);
      check("midrst_rsp_id", rsp_id, '0);
      check("midrst_rsp_result", rsp_result, '0);
      check("midrst_fpu_op1", fpu_op1, '0);
      check("midrst_fpu_op2", fpu_op2, '0);
      check("midrst_fpu_opc", fpu_opc, '0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_ready", req_ready, '0);
      @(posedge CLK);
      #3;
      RST_N = 1'b1;
      quiet = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge CLK);
         if (rsp_valid) quiet++;
      end
      check("midrst_no_rsp", quiet, 0);
      tick();
      req_valid = '1;
      rand_ops();
      @(negedge CLK);
      check("midrst_first_grant", req_ready, 4'b0001);

      // Idle hold: FPU inputs keep the last issued op, no responses.
      idle_wait();
      for (int c = 0; c < 50; c++) begin
         @(negedge CLK);
         check("idle_fpu_hold", {fpu_op1, fpu_op2, fpu_opc}, {last_op1, last_op2, last_opc});
         check("idle_rsp_valid", rsp_valid, 1'b0);
      end

      check("scoreboard_empty", sb_q.size(), 0);
      check("ready_onehot_errors", onehot_err, 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
